// File: rtl/mfe_lcd1602_sequencer.sv
// rtl/mfe_lcd1602_sequencer.sv - LCD1602 power-up, init and frame sequencer with 32-byte char buffer
// Optional periodic redraw: define MFE_LCD1602_AUTO_REFRESH_EN.
module mfe_lcd1602_sequencer #(
  parameter int PWUP_CYCLES    = 4000000,
  parameter int REFRESH_CYCLES = 2500000,
  parameter int T_WIDTH        = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_cmd,
  output logic [7:0] lcd_dat,
  output logic       lcd_vld,
  output logic       lcd_lwt,
  input  logic       lcd_ready
);

  typedef enum logic [1:0] {S_PWUP, S_ISSUE, S_WAIT, S_IDLE} state_t;

  localparam logic [T_WIDTH-1:0] PWUP_LAST = T_WIDTH'(PWUP_CYCLES - 1);

  if (((PWUP_CYCLES >> T_WIDTH) != 0) || ((REFRESH_CYCLES >> T_WIDTH) != 0)) begin : g_bad_param
    $error("cycle parameter does not fit in T_WIDTH");
  end

  state_t             state_q, state_d;
  logic               mode_q, mode_d;       // 0: INIT, 1: FRAME
  logic [5:0]         idx_q, idx_d;
  logic               pend_q, pend_d;
  logic               init_done_q, init_done_d;
  logic [T_WIDTH-1:0] timer_q, timer_d;
  logic [7:0]         chr_q [32];
  logic               refresh_tick;
  logic               refresh_any;
  logic               last_step;
  logic [4:0]         pos;

`ifdef MFE_LCD1602_AUTO_REFRESH_EN
  localparam logic [T_WIDTH-1:0] REFRESH_LAST = T_WIDTH'(REFRESH_CYCLES - 1);
  logic [T_WIDTH-1:0] ref_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q <= '0;
    end else if (init_done_q) begin
      ref_cnt_q <= (ref_cnt_q == REFRESH_LAST) ? '0 : ref_cnt_q + 1'b1;
    end
  end

  assign refresh_tick = init_done_q && (ref_cnt_q == REFRESH_LAST);
`else
  assign refresh_tick = 1'b0;
`endif

  assign refresh_any = refresh | refresh_tick;
  assign busy        = (state_q != S_IDLE);
  assign init_done   = init_done_q;
  assign lcd_vld     = (state_q == S_ISSUE) && lcd_ready;
  assign last_step   = mode_q ? (idx_q == 6'd33) : (idx_q == 6'd3);
  // Steps 1-16 map to buf[0..15], 18-33 to buf[16..31]; 5-bit wrap keeps the math exact.
  assign pos         = idx_q[4:0] - ((idx_q <= 6'd16) ? 5'd1 : 5'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) chr_q[i] <= 8'h20;
    end else if (wr_en) begin
      chr_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    lcd_cmd = 1'b1;
    lcd_dat = 8'h00;
    lcd_lwt = 1'b0;
    if (!mode_q) begin
      case (idx_q[1:0])
        2'd0: lcd_dat = 8'h38;
        2'd1: lcd_dat = 8'h0C;
        2'd2: lcd_dat = 8'h06;
        default: begin
          lcd_dat = 8'h01;
          lcd_lwt = 1'b1;
        end
      endcase
    end else if (idx_q == 6'd0) begin
      lcd_dat = 8'h80;
    end else if (idx_q == 6'd17) begin
      lcd_dat = 8'hC0;
    end else begin
      lcd_cmd = 1'b0;
      lcd_dat = chr_q[pos];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PWUP;
      mode_q      <= 1'b0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      init_done_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      init_done_q <= init_done_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    pend_d      = pend_q | (refresh_any && (state_q != S_IDLE));
    init_done_d = init_done_q;
    timer_d     = timer_q;
    case (state_q)
      S_PWUP: begin
        if (timer_q == PWUP_LAST) begin
          state_d = S_ISSUE;
          mode_d  = 1'b0;
          idx_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (lcd_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lcd_ready) begin
          if (!last_step) begin
            idx_d   = idx_q + 6'd1;
            state_d = S_ISSUE;
          end else if (!mode_q) begin
            init_done_d = 1'b1;
            mode_d      = 1'b1;
            idx_d       = '0;
            state_d     = S_ISSUE;
          end else if (pend_q || refresh_any) begin
            pend_d  = 1'b0;
            idx_d   = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        if (refresh_any) begin
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
    endcase
  end

endmodule

// File: doc/mfe_lcd1602_sequencer.md
# mfe_lcd1602_sequencer

Frame sequencer for the LCD1602 character display. It sits upstream of the LCD1602 controller (cmd/dat/vld/lwt/ready port) and performs three jobs: the power-up wait, the HD44780 init command sequence, and full 2x16 screen refreshes. Screen content comes from an internal 32-byte character buffer that user logic writes. The block owns the controller's input port exclusively.

## Interface
Parameters:
- `PWUP_CYCLES`, 4000000: cycles from reset release to the first init command (40 ms at 100 MHz).
- `REFRESH_CYCLES`, 2500000: auto-refresh period in cycles. Used only with `MFE_LCD1602_AUTO_REFRESH_EN`.
- `T_WIDTH`, 22: timer width. Both cycle parameters must be < 2^T_WIDTH.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  5  character position; 0-15 is row 0, 16-31 is row 1.
- `wr_data`  in  8  character code.
- `refresh`  in  1  single-cycle pulse requesting a full-screen redraw.
- `busy`  out  1  high whenever state != S_IDLE.
- `init_done`  out  1  set once the init sequence completes; cleared only by `rst`.
- `lcd_cmd`  out  1  to controller `cmd`; 1 = instruction, 0 = character data.
- `lcd_dat`  out  8  to controller `dat`.
- `lcd_vld`  out  1  to controller `vld`.
- `lcd_lwt`  out  1  to controller `lwt`; 1 requests the long wait.
- `lcd_ready`  in  1  from controller `ready`.

## Operation
- **Buffer.** 32x8 registers, reset to 0x20 (space). On each clock with `wr_en`=1, `buf[wr_addr]` <= `wr_data`. Writes are accepted in every state.
- **States:** S_PWUP, S_ISSUE, S_WAIT, S_IDLE. A `mode` flag selects INIT or FRAME. A step index `idx` selects the transaction.
- **INIT steps 0-3:** 0x38, 0x0C, 0x06, 0x01. All have `lcd_cmd`=1. Only 0x01 has `lcd_lwt`=1.
- **FRAME steps 0-33:**
  - step 0: 0x80 (cmd).
  - steps 1-16: `buf[0..15]` (data).
  - step 17: 0xC0 (cmd).
  - steps 18-33: `buf[16..31]` (data).
  - `lcd_lwt`=0 for every FRAME step.
- `lcd_cmd`, `lcd_dat` and `lcd_lwt` are combinational from `mode`, `idx` and the buffer. A write to the position being issued in the same cycle sends the old value.
- **Handshake:** `lcd_vld` = (state==S_ISSUE) & `lcd_ready`.
- **S_PWUP:** counts `PWUP_CYCLES` cycles, then goes to S_ISSUE with mode=INIT, idx=0.
- **S_ISSUE:** if `lcd_ready`=1, go to S_WAIT. Otherwise hold.
- **S_WAIT:** wait for `lcd_ready`=1, then apply the first matching rule:
  - not the last step: idx++, go to S_ISSUE.
  - last INIT step: set `init_done`, go to mode=FRAME, idx=0, S_ISSUE. The first frame is automatic.
  - last FRAME step with a pending request: clear the request, start a new frame (idx=0, S_ISSUE).
  - otherwise: go to S_IDLE.
- **S_IDLE:** `refresh`=1 starts a frame (S_ISSUE, idx=0).
- **Pending request:** a `refresh` pulse in S_PWUP, S_ISSUE or S_WAIT sets `pend`. Multiple pulses collapse into one redraw. `refresh` in the cycle that ends a frame is treated as pending, so a new frame starts immediately.

## Timing
- **Reset values:**
  - state=S_PWUP, `busy`=1, `init_done`=0, `lcd_vld`=0.
  - `lcd_cmd`=1, `lcd_dat`=0x38, `lcd_lwt`=0 (INIT step 0).
  - `pend`=0.
- **Async reset mid-transaction:** `lcd_vld` drops immediately and the sequence restarts from power-up. The buffer resets to spaces.
- **Power-up:** the first `lcd_vld` occurs exactly `PWUP_CYCLES` cycles after `rst` deasserts, provided `lcd_ready`=1.
- **Refresh latency:** `refresh` sampled in S_IDLE at edge t gives `lcd_vld`=1 in the cycle after t, if `lcd_ready`=1.
- **Pulse width:** `lcd_vld` is never high for two consecutive cycles. The controller drops `ready` one cycle after accepting, so S_WAIT never mis-samples.
- **Transaction counts:** a frame is exactly 34 `lcd_vld` pulses. Init is exactly 4.

## Configuration
- **`MFE_LCD1602_AUTO_REFRESH_EN` defined:**
  - a T_WIDTH-bit counter runs while `init_done`=1.
  - it wraps at `REFRESH_CYCLES`-1, producing a one-cycle tick.
  - the tick is ORed with `refresh` and obeys the same pending rules.
- **Undefined:** no counter exists. Frames occur only after init and on `refresh`.

## Test plan
- **Power-up and init:** release `rst`, `PWUP_CYCLES`=100, model controller ready after 10 cycles busy.
  - first `lcd_vld` at cycle 100.
  - transactions 0x38, 0x0C, 0x06, 0x01 (the 0x01 with `lcd_lwt`=1).
  - then 34 frame transactions of spaces, `init_done`=1, `busy`=0.
- **Buffer write and refresh:** write "HELLO" to 0-4 and "FPGA" to 16-19, pulse `refresh`.
  - 0x80, 0x48 0x45 0x4C 0x4C 0x4F, eleven 0x20.
  - 0xC0, 0x46 0x50 0x47 0x41, twelve 0x20.
- **Refresh during a frame:** pulse `refresh` three times mid-frame.
  - exactly one additional frame starts directly after step 33, with no S_IDLE cycle.
- **Ready held low:** hold `lcd_ready`=0 for 50 cycles in S_ISSUE.
  - `lcd_vld` stays 0.
  - exactly one pulse once ready rises.
- **Mid-frame reset:** assert `rst` at step 20.
  - `lcd_vld`=0 immediately, `init_done`=0, buffer reads 0x20.
  - init repeats from 0x38.
- **Auto-refresh:** with `MFE_LCD1602_AUTO_REFRESH_EN` and `REFRESH_CYCLES`=1000, idle the inputs.
  - a 34-transaction frame starts every 1000 cycles.
  - without the macro, no frames after the first.
